// File: rtl/eq_scoreboard.sv
// In-order equivalence checker: queues expected values and compares them against actual values.
// Define EQ_SCOREBOARD_ASSERT_EN to compile a concurrent assertion on prop.
module eq_scoreboard #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int MAX_LAT = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     exp_valid,
    input  logic [WIDTH-1:0]         exp_data,
    input  logic                     act_valid,
    input  logic [WIDTH-1:0]         act_data,
    output logic                     match_pulse,
    output logic                     err,
    output logic [2:0]               err_code,
    output logic [$clog2(DEPTH):0]   pending,
    output logic [15:0]              match_count,
    output logic                     prop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {
        CODE_NONE      = 3'd0,
        CODE_MISMATCH  = 3'd1,
        CODE_UNDERFLOW = 3'd2,
        CODE_OVERFLOW  = 3'd3,
        CODE_TIMEOUT   = 3'd4
    } err_code_t;

    // Highest-priority cause among errors detected in the same cycle.
    function automatic logic [2:0] first_cause(input logic mm, input logic uf,
                                               input logic of, input logic to);
        if (mm)      return CODE_MISMATCH;
        else if (uf) return CODE_UNDERFLOW;
        else if (of) return CODE_OVERFLOW;
        else if (to) return CODE_TIMEOUT;
        else         return CODE_NONE;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [AW-1:0]    age;

    logic             empty_p0, full_p0;
    logic             bypass_p0, pop_p0, push_p0;
    logic             vld_p0, cmp_eq_p0;
    logic [WIDTH-1:0] cmp_data_p0;
    logic             mm_p0, uf_p0, of_p0, to_p0, any_err_p0;
    logic [2:0]       cause_p0;

    // Stage p0: decode queue operation and compare against the head (or bypass).
    always_comb begin
        empty_p0    = (count == '0);
        full_p0     = (count == CW'(DEPTH));
        bypass_p0   = empty_p0 && exp_valid && act_valid;
        pop_p0      = act_valid && !empty_p0;
        push_p0     = exp_valid && !bypass_p0 && (!full_p0 || act_valid);
        vld_p0      = bypass_p0 || pop_p0;
        cmp_data_p0 = bypass_p0 ? exp_data : mem[rd_ptr];
        cmp_eq_p0   = (cmp_data_p0 == act_data);
        mm_p0       = vld_p0 && !cmp_eq_p0;
        uf_p0       = act_valid && !exp_valid && empty_p0;
        of_p0       = exp_valid && !act_valid && full_p0;
        to_p0       = !empty_p0 && !pop_p0 && (age == AW'(MAX_LAT - 1));
        any_err_p0  = mm_p0 || uf_p0 || of_p0 || to_p0;
        cause_p0    = first_cause(mm_p0, uf_p0, of_p0, to_p0);
    end

    always_ff @(posedge clk) begin
        if (push_p0)
            mem[wr_ptr] <= exp_data;
    end

    // Stage p1: registered queue state, flags and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            age         <= '0;
            match_pulse <= 1'b0;
            err         <= 1'b0;
            err_code    <= CODE_NONE;
            match_count <= '0;
        end else begin
            if (push_p0)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop_p0)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_p0, pop_p0})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (pop_p0 || empty_p0)
                age <= '0;
            else if (age != AW'(MAX_LAT))
                age <= age + AW'(1);
            match_pulse <= vld_p0 && cmp_eq_p0;
            if (vld_p0 && cmp_eq_p0)
                match_count <= sat_inc(match_count);
            if (any_err_p0) begin
                err <= 1'b1;
                if (!err)
                    err_code <= cause_p0;
            end
        end
    end

    assign pending = count;
    assign prop    = !err;

`ifdef EQ_SCOREBOARD_ASSERT_EN
    prop_a: assert property (@(posedge clk) disable iff (reset) prop);
`else
`endif

endmodule

// File: tb/tb_eq_scoreboard.sv
// Directed bench for eq_scoreboard with a queue-based reference model of the expected stream.
module tb_eq_scoreboard;
    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int MAX_LAT = 7;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   exp_valid, act_valid;
    logic [WIDTH-1:0]       exp_data, act_data;
    logic                   match_pulse, err, prop;
    logic [2:0]             err_code;
    logic [$clog2(DEPTH):0] pending;
    logic [15:0]            match_count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] q[$];
    int  m_age, m_code, m_cnt;
    bit  m_match, m_err;

    eq_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT)) dut (
        .clk(clk), .reset(reset),
        .exp_valid(exp_valid), .exp_data(exp_data),
        .act_valid(act_valid), .act_data(act_data),
        .match_pulse(match_pulse), .err(err), .err_code(err_code),
        .pending(pending), .match_count(match_count), .prop(prop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".match_pulse"}, 32'(match_pulse), 32'(m_match));
        check({tag, ".err"},         32'(err),         32'(m_err));
        check({tag, ".err_code"},    32'(err_code),    32'(m_code));
        check({tag, ".pending"},     32'(pending),     32'(q.size()));
        check({tag, ".match_count"}, 32'(match_count), 32'(m_cnt));
        check({tag, ".prop"},        32'(prop),        32'(!m_err));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; exp_valid = 1'b0; act_valid = 1'b0; exp_data = '0; act_data = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete(); m_age = 0; m_code = 0; m_cnt = 0; m_match = 0; m_err = 0;
        check_all(tag);
    endtask

    task automatic step(input bit ev, input logic [WIDTH-1:0] ed,
                        input bit av, input logic [WIDTH-1:0] ad, input string tag);
        bit empty0, full0, pop, cmp, eq, mm, uf, of, to;
        int code;
        logic [WIDTH-1:0] h;
        exp_valid = ev; exp_data = ed; act_valid = av; act_data = ad;
        empty0 = (q.size() == 0);
        full0  = (q.size() == DEPTH);
        pop    = av && !empty0;
        cmp = 0; eq = 0;
        if (ev && av && empty0) begin
            cmp = 1; eq = (ed == ad);
        end else if (pop) begin
            h = q.pop_front(); cmp = 1; eq = (h == ad);
        end
        uf = av && !ev && empty0;
        of = 0;
        if (ev && !(av && empty0)) begin
            if (full0 && !av) of = 1;
            else q.push_back(ed);
        end
        to = !empty0 && !pop && (m_age == MAX_LAT - 1);
        if (pop || empty0) m_age = 0;
        else if (m_age < MAX_LAT) m_age++;
        mm = cmp && !eq;
        m_match = cmp && eq;
        if (m_match && m_cnt < 16'hFFFF) m_cnt++;
        code = mm ? 1 : uf ? 2 : of ? 3 : to ? 4 : 0;
        if (!m_err && code != 0) m_code = code;
        if (code != 0) m_err = 1;
        @(posedge clk); #1;
        exp_valid = 1'b0; act_valid = 1'b0;
        check_all(tag);
    endtask

    initial begin
        do_reset("reset");

        // Bypass compares on an empty queue.
        for (int i = 0; i < 3; i++) step(1, 8'h5A, 1, 8'h5A, "bypass");
        check("bypass.count", 32'(match_count), 32'd3);
        check("bypass.pending", 32'(pending), 32'd0);

        // Three-cycle latency.
        step(1, 8'h11, 0, 8'h00, "lat.push");
        step(1, 8'h22, 0, 8'h00, "lat.push");
        step(1, 8'h33, 0, 8'h00, "lat.push");
        check("lat.peak", 32'(pending), 32'd3);
        step(0, 8'h00, 1, 8'h11, "lat.pop");
        step(0, 8'h00, 1, 8'h22, "lat.pop");
        step(0, 8'h00, 1, 8'h33, "lat.pop");
        check("lat.count", 32'(match_count), 32'd6);
        check("lat.err", 32'(err), 32'd0);

        // Full queue with simultaneous push and pop, then drain.
        do_reset("reset2");
        for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 8'h00, "full.push");
        for (int i = 1; i <= 4; i++) step(1, 8'(i + 4), 1, 8'(i), "full.pushpop");
        check("full.pending", 32'(pending), 32'd4);
        for (int i = 5; i <= 8; i++) step(0, 8'h00, 1, 8'(i), "full.drain");
        check("full.err", 32'(err), 32'd0);

        // Mismatch is sticky.
        do_reset("reset3");
        step(1, 8'hA0, 0, 8'h00, "mm.push");
        step(0, 8'h00, 0, 8'h00, "mm.idle");
        step(0, 8'h00, 1, 8'hA1, "mm.pop");
        check("mm.code", 32'(err_code), 32'd1);
        check("mm.prop", 32'(prop), 32'd0);
        step(1, 8'h42, 1, 8'h42, "mm.after");
        check("mm.sticky", 32'(err), 32'd1);

        // Overflow drops the fifth value; queue keeps working afterward.
        do_reset("reset4");
        for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 8'h00, "of.push");
        check("of.code", 32'(err_code), 32'd3);
        check("of.pending", 32'(pending), 32'd4);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 8'(8'hC0 + i), "of.drain");

        // Timeout after MAX_LAT unpopped cycles.
        do_reset("reset5");
        step(1, 8'h77, 0, 8'h00, "to.push");
        for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 8'h00, "to.wait");
        check("to.before", 32'(err), 32'd0);
        step(0, 8'h00, 0, 8'h00, "to.fire");
        check("to.code", 32'(err_code), 32'd4);

        // Underflow.
        do_reset("reset6");
        step(0, 8'h00, 1, 8'h12, "uf");
        check("uf.code", 32'(err_code), 32'd2);

        // Overflow and timeout in the same cycle: overflow wins.
        do_reset("reset7");
        for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 8'h00, "pri.push");
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 8'h00, "pri.idle");
        step(1, 8'h14, 0, 8'h00, "pri.both");
        check("pri.code", 32'(err_code), 32'd3);

        // Reset mid-operation.
        do_reset("reset8");
        step(1, 8'h01, 0, 8'h00, "mid.push");
        step(1, 8'h02, 0, 8'h00, "mid.push");
        do_reset("mid.reset");
        check("mid.pending", 32'(pending), 32'd0);
        check("mid.count", 32'(match_count), 32'd0);
        step(1, 8'hFF, 1, 8'hFF, "mid.bypass");
        check("mid.match", 32'(match_pulse), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
